// File: rtl/mem_dma.sv
// mem_dma: block FILL/COPY/SUM engine that owns the 16x8 data RAM port while busy
// Ports: start/op/src_addr/dst_addr/len/fill_data issue a command (sampled in IDLE only);
//        busy/done/err/result report it; MemWrite/MemRead/Address/WriteData/MemData_out are the RAM port.
//        All outputs are registered, so bus values are computed from the next state and next index.
module mem_dma #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] MemData_out
);
  typedef enum logic [2:0] {IDLE, FILL_WR, CPY_RD, CPY_WR, SUM_RD, DONE} state_t;
  state_t state, nState;
  logic [ADDR_W:0] idx, nIdx, idxInc, lenR;
  logic [ADDR_W-1:0] srcR, dstR, src, dst, nAddr;
  logic [DATA_W-1:0] fillR, fill, hold, nHold, acc, nSum, nWData;
  logic accept, last;
  always_comb begin
    accept = state == IDLE && start;
    idxInc = idx + (ADDR_W+1)'(1);
    last = idxInc == lenR;
    nState = state;
    nIdx = idx;
    case (state)
      IDLE: if (start) begin
        nIdx = '0;
        nState = (len == '0 || op == 2'b11) ? DONE : op == 2'b00 ? FILL_WR : op == 2'b01 ? CPY_RD : SUM_RD;
      end
      FILL_WR, SUM_RD: begin
        nIdx = idxInc;
        nState = last ? DONE : state;
      end
      CPY_RD: nState = CPY_WR;
      CPY_WR: begin
        nIdx = idxInc;
        nState = last ? DONE : CPY_RD;
      end
      default: nState = IDLE;
    endcase
    // on the accepting edge the latches are not loaded yet, so take the command inputs directly
    src = accept ? src_addr : srcR;
    dst = accept ? dst_addr : dstR;
    fill = accept ? fill_data : fillR;
    nHold = state == CPY_RD ? MemData_out : hold;
    nSum = acc + MemData_out;
    nAddr = (nState == FILL_WR || nState == CPY_WR) ? dst + nIdx[ADDR_W-1:0] :
            (nState == CPY_RD || nState == SUM_RD) ? src + nIdx[ADDR_W-1:0] : '0;
    nWData = nState == FILL_WR ? fill : nState == CPY_WR ? nHold : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      lenR <= '0;
      srcR <= '0;
      dstR <= '0;
      fillR <= '0;
      hold <= '0;
      acc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      result <= '0;
      MemWrite <= 1'b0;
      MemRead <= 1'b0;
      Address <= '0;
      WriteData <= '0;
    end else begin
      state <= nState;
      idx <= nIdx;
      hold <= nHold;
      busy <= nState != IDLE;
      done <= nState == DONE;
      MemWrite <= nState == FILL_WR || nState == CPY_WR;
      MemRead <= nState == CPY_RD || nState == SUM_RD;
      Address <= nAddr;
      WriteData <= nWData;
      if (accept) begin
        lenR <= len;
        srcR <= src_addr;
        dstR <= dst_addr;
        fillR <= fill_data;
        err <= op == 2'b11;
        acc <= '0;
        if (op == 2'b10 && len == '0) result <= '0;
      end
      if (state == SUM_RD) begin
        acc <= nSum;
        if (last) result <= nSum;
      end
    end
  end
endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: table-driven and randomized checks of mem_dma against a RAM model and a per-command reference model
module tb_mem_dma;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [1:0] op = '0;
  logic [3:0] src_addr = '0, dst_addr = '0;
  logic [4:0] len = '0;
  logic [7:0] fill_data = '0;
  logic busy, done, err, MemWrite, MemRead;
  logic [7:0] result, WriteData, MemData_out;
  logic [3:0] Address;
  logic [7:0] ram [16];
  logic tbWe = 1'b0;
  logic [3:0] tbA = '0;
  logic [7:0] tbD = '0;
  logic [7:0] modelRes = '0;
  int total = 0, bad = 0;

  mem_dma dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fill_data(fill_data), .busy(busy), .done(done), .err(err), .result(result),
    .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address), .WriteData(WriteData),
    .MemData_out(MemData_out)
  );

  always #5 clk = ~clk;
  assign MemData_out = ram[Address];
  always @(posedge clk)
    if (MemWrite) ram[Address] <= WriteData;
    else if (tbWe) ram[tbA] <= tbD;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    tbWe = 1'b1;
    tbA = a;
    tbD = d;
    @(negedge clk);
    tbWe = 1'b0;
  endtask

  // Issues a command in the current (idle) cycle, scrambles start and command inputs while busy,
  // and checks the outcome against the reference result computed from the RAM image beforehand.
  task automatic run_cmd(input logic [1:0] o, input logic [3:0] s, input logic [3:0] d,
                         input logic [4:0] l, input logic [7:0] f, output int cyc);
    logic [7:0] m [16];
    logic [7:0] sum;
    int eCyc, eWr, eRd, wr, rd, bus, dn, dl, miss;
    for (int i = 0; i < 16; i++) m[i] = ram[i];
    sum = '0;
    for (int i = 0; i < int'(l); i++)
      case (o)
        2'd0: m[4'(d + i)] = f;
        2'd1: m[4'(d + i)] = m[4'(s + i)];
        2'd2: sum += m[4'(s + i)];
        default: ;
      endcase
    eCyc = (l == 0 || o == 2'd3) ? 1 : o == 2'd1 ? 2 * int'(l) + 1 : int'(l) + 1;
    eWr = (o == 2'd0 || o == 2'd1) ? int'(l) : 0;
    eRd = (o == 2'd1 || o == 2'd2) ? int'(l) : 0;
    if (o == 2'd2) modelRes = sum;
    chk("gap_busy", int'(busy), 0);
    start = 1'b1; op = o; src_addr = s; dst_addr = d; len = l; fill_data = f;
    @(negedge clk);
    cyc = 0; wr = 0; rd = 0; bus = 0; dn = 0; dl = 0;
    while (busy && cyc < 64) begin
      cyc++;
      wr += int'(MemWrite);
      rd += int'(MemRead);
      if (MemWrite && MemRead) bus++;
      if (!MemWrite && !MemRead && (Address != 0 || WriteData != 0)) bus++;
      dn += int'(done);
      dl = int'(done);
      start = cyc == 1 ? 1'b1 : 1'($urandom);
      op = 2'($urandom); src_addr = 4'($urandom); dst_addr = 4'($urandom);
      len = 5'($urandom); fill_data = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    miss = 0;
    for (int i = 0; i < 16; i++) if (ram[i] != m[i]) miss++;
    chk("busy_cycles", cyc, eCyc);
    chk("writes", wr, eWr);
    chk("reads", rd, eRd);
    chk("bus_rules", bus, 0);
    chk("done_count", dn, 1);
    chk("done_last", dl, 1);
    chk("err", int'(err), int'(o == 2'd3));
    chk("result", int'(result), int'(modelRes));
    chk("ram_mismatches", miss, 0);
  endtask

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] s;
    logic [3:0] d;
    logic [4:0] l;
    logic [7:0] f;
    logic [5:0] cyc;
    logic [7:0] res;
    logic [2:0] pn;
    logic [3:0][3:0] pa;
    logic [3:0][7:0] pd;
  } vec_t;

  vec_t vt [8];

  initial begin
    int cyc, wr, dn;
    vt[0] = '{2'd0, 4'd0, 4'd2, 5'd3, 8'hAA, 6'd4, 8'h00, 3'd0, 16'h0, 32'h0};
    vt[1] = '{2'd2, 4'd0, 4'd0, 5'd4, 8'h00, 6'd5, 8'h11, 3'd4, 16'h3210, 32'h0001_20F0};
    vt[2] = '{2'd1, 4'd14, 4'd5, 5'd3, 8'h00, 6'd7, 8'h00, 3'd3, 16'h00FE, 32'h0033_2211};
    vt[3] = '{2'd0, 4'd0, 4'd9, 5'd0, 8'h77, 6'd1, 8'h00, 3'd0, 16'h0, 32'h0};
    vt[4] = '{2'd3, 4'd3, 4'd3, 5'd5, 8'h00, 6'd1, 8'h00, 3'd0, 16'h0, 32'h0};
    vt[5] = '{2'd2, 4'd4, 4'd0, 5'd0, 8'h00, 6'd1, 8'h00, 3'd0, 16'h0, 32'h0};
    vt[6] = '{2'd1, 4'd3, 4'd4, 5'd4, 8'h00, 6'd9, 8'h00, 3'd0, 16'h0, 32'h0};
    vt[7] = '{2'd0, 4'd0, 4'd7, 5'd16, 8'h5C, 6'd17, 8'h00, 3'd0, 16'h0, 32'h0};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_memwrite", int'(MemWrite), 0);
    chk("rst_memread", int'(MemRead), 0);
    chk("rst_address", int'(Address), 0);
    chk("rst_writedata", int'(WriteData), 0);
    for (int i = 0; i < 16; i++) poke(4'(i), 8'h00);
    for (int t = 0; t < 8; t++) begin
      for (int p = 0; p < int'(vt[t].pn); p++) poke(vt[t].pa[p], vt[t].pd[p]);
      run_cmd(vt[t].op, vt[t].s, vt[t].d, vt[t].l, vt[t].f, cyc);
      chk($sformatf("vec%0d_cycles", t), cyc, int'(vt[t].cyc));
      if (vt[t].op == 2'd2) chk($sformatf("vec%0d_result", t), int'(result), int'(vt[t].res));
    end
    chk("fill_ram1", int'(ram[1]), 8'h5C);
    start = 1'b1; op = 2'd0; dst_addr = 4'd0; len = 5'd8; fill_data = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midfill_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelRes = '0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_memwrite", int'(MemWrite), 0);
    chk("abort_address", int'(Address), 0);
    wr = 0; dn = 0;
    repeat (4) begin
      wr += int'(MemWrite);
      dn += int'(done);
      @(negedge clk);
    end
    chk("abort_quiet", wr + dn, 0);
    reset = 1'b1; start = 1'b1; op = 2'd0; len = 5'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy", int'(busy), 0);
    @(negedge clk);
    chk("rst_start_dropped", int'(busy) + int'(MemWrite), 0);
    for (int i = 0; i < 16; i++) poke(4'(i), 8'($urandom));
    repeat (40) run_cmd(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                        5'($urandom_range(0, 16)), 8'($urandom), cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
